reflet_boot_mapper: RTL and testbench

REFLET_BOOT_MAPPER -- requirements
Module: reflet_boot_mapper

---
 rtl/reflet_boot_mapper.sv | 186 ++++++++++++++++++
 tb/tb_reflet_boot_mapper.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_boot_mapper.sv
// rtl/reflet_boot_mapper.sv - boot-ROM overlay address mapper with unmap control register
//
// Maps a boot-ROM window over the low address space until software writes the
// unmap key to the control register. Reads inside the window go to the ROM,
// everything else goes to RAM. Writes always target RAM, so code can pre-load
// the RAM shadowed by the ROM before unmapping it.
//
// Optional feature macro: REFLET_BOOT_WP_EN
//   defined   - writes inside the mapped window are dropped, acknowledged, and
//               latch the sticky wp_fault flag until reset.
//   undefined - writes inside the window shadow into RAM; wp_fault is tied 0.
//
// Ports:
//   clk, reset            sole clock (rising edge), synchronous active-high reset
//   cpu_addr/cpu_wdata    CPU byte address and write data
//   cpu_write_en/read_en  single-cycle request strobes (write wins if both set)
//   cpu_rdata/cpu_ready   response data and one-cycle completion pulse
//   rom_enable/rom_addr   boot ROM request (combinational), rom_data 1-cycle later
//   ram_enable/ram_write_en/ram_addr/ram_wdata  RAM request (combinational)
//   ram_rdata             RAM read data, 1-cycle latency
//   boot_active           1 while the ROM window is mapped
//   wp_fault              sticky write-protect fault

`timescale 1ns/1ps

module reflet_boot_mapper #(
    parameter logic [15:0] ROM_BASE  = 16'h7E00,
    parameter int          ROM_SIZE  = 512,
    parameter logic [15:0] CTRL_ADDR = 16'hFFF0,
    parameter logic [7:0]  UNMAP_KEY = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        rom_enable,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        ram_enable,
    output logic        ram_write_en,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        boot_active,
    output logic        wp_fault
);

    // 17-bit bounds so ROM_BASE+ROM_SIZE cannot wrap around to a small value.
    localparam logic [16:0] WIN_LO = {1'b0, ROM_BASE};
    localparam logic [16:0] WIN_HI = WIN_LO + 17'(ROM_SIZE);

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_ROM,
        SRC_RAM,
        SRC_CTRL
    } src_t;

    logic        r_boot_active;
    logic        r_ready;
    src_t        r_src;
    logic        r_ctrl_val;
    logic [14:0] r_rom_addr;
    logic [15:0] r_ram_addr;
    logic [7:0]  r_ram_wdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_is_ctrl;
    logic        w_in_win;
    logic        w_rom_rd;
    logic        w_ram_rd;
    logic        w_ram_wr;
    logic        w_wp_drop;
    logic        w_unmap;

    // Write has priority: a cycle with both strobes is a write only.
    assign w_wr      = cpu_write_en & ~reset;
    assign w_rd      = cpu_read_en & ~cpu_write_en & ~reset;
    assign w_is_ctrl = (cpu_addr == CTRL_ADDR);
    assign w_in_win  = r_boot_active
                     && ({1'b0, cpu_addr} >= WIN_LO)
                     && ({1'b0, cpu_addr} <  WIN_HI);

    // The control register is decoded first so it never reaches either memory.
    assign w_rom_rd  = w_rd & ~w_is_ctrl &  w_in_win;
    assign w_ram_rd  = w_rd & ~w_is_ctrl & ~w_in_win;

`ifdef REFLET_BOOT_WP_EN
    assign w_wp_drop = w_wr & ~w_is_ctrl & w_in_win;
`else
    assign w_wp_drop = 1'b0;
`endif

    assign w_ram_wr  = w_wr & ~w_is_ctrl & ~w_wp_drop;
    assign w_unmap   = w_wr & w_is_ctrl & (cpu_wdata == UNMAP_KEY);

    // Strobes are combinational; address/data buses hold their last driven
    // value on idle cycles so the memories see no spurious toggling.
    assign rom_enable   = w_rom_rd;
    assign rom_addr     = w_rom_rd ? cpu_addr[14:0] : r_rom_addr;
    assign ram_enable   = w_ram_rd | w_ram_wr;
    assign ram_write_en = w_ram_wr;
    assign ram_addr     = (w_ram_rd | w_ram_wr) ? cpu_addr : r_ram_addr;
    assign ram_wdata    = w_ram_wr ? cpu_wdata : r_ram_wdata;

    assign boot_active  = r_boot_active;

    // Gating with reset kills a response that was already registered when
    // reset arrives, so an in-flight read never completes.
    assign cpu_ready    = r_ready & ~reset;

    always_comb begin
        cpu_rdata = 8'h00;
        if (r_ready && !reset) begin
            case (r_src)
                SRC_ROM:  cpu_rdata = rom_data;
                SRC_RAM:  cpu_rdata = ram_rdata;
                SRC_CTRL: cpu_rdata = {7'b0, r_ctrl_val};
                default:  cpu_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_boot_active <= 1'b1;
            r_ready       <= 1'b0;
            r_src         <= SRC_ZERO;
            r_ctrl_val    <= 1'b0;
            r_rom_addr    <= 15'h0000;
            r_ram_addr    <= 16'h0000;
            r_ram_wdata   <= 8'h00;
        end else begin
            r_ready <= w_wr | w_rd;

            if (w_rom_rd) begin
                r_src <= SRC_ROM;
            end else if (w_ram_rd) begin
                r_src <= SRC_RAM;
            end else if (w_rd) begin
                r_src <= SRC_CTRL;
            end else begin
                r_src <= SRC_ZERO;
            end

            // Status read returns the mapping state as seen before this edge.
            r_ctrl_val <= r_boot_active;

            if (w_unmap) begin
                r_boot_active <= 1'b0;
            end

            if (w_rom_rd) begin
                r_rom_addr <= cpu_addr[14:0];
            end
            if (w_ram_rd | w_ram_wr) begin
                r_ram_addr <= cpu_addr;
            end
            if (w_ram_wr) begin
                r_ram_wdata <= cpu_wdata;
            end
        end
    end

`ifdef REFLET_BOOT_WP_EN
    logic r_wp_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp_fault <= 1'b0;
        end else if (w_wp_drop) begin
            r_wp_fault <= 1'b1;
        end
    end

    assign wp_fault = r_wp_fault;
`else
    assign wp_fault = 1'b0;
`endif

endmodule

// File: tb/tb_reflet_boot_mapper.sv
// tb/tb_reflet_boot_mapper.sv - scoreboard bench for reflet_boot_mapper

`timescale 1ns/1ps

module tb_reflet_boot_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        rom_enable;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        ram_enable;
    logic        ram_write_en;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        boot_active;
    logic        wp_fault;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] ram_w[logic [15:0]];

    reflet_boot_mapper dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_write_en (cpu_write_en),
        .cpu_read_en  (cpu_read_en),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .rom_enable   (rom_enable),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .ram_enable   (ram_enable),
        .ram_write_en (ram_write_en),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .boot_active  (boot_active),
        .wp_fault     (wp_fault)
    );

    always #5 clk = ~clk;

    // Memory models: ROM byte = low address byte + 0x10; RAM background
    // pattern = addr[7:0] ^ addr[15:8] ^ 0x5A, overridden by writes.
    function automatic logic [7:0] ram_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (rom_enable) begin
            rom_data <= rom_addr[7:0] + 8'h10;
        end
        if (ram_enable) begin
            if (ram_write_en) begin
                ram_w[ram_addr] = ram_wdata;
            end else begin
                ram_rdata <= ram_w.exists(ram_addr) ? ram_w[ram_addr] : ram_fn(ram_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_read_en  = rd;
        cpu_write_en = wr;
        cpu_addr     = a;
        cpu_wdata    = d;
    endtask

    task automatic idle();
        cpu_read_en  = 1'b0;
        cpu_write_en = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completion pops the oldest expected response.
    always @(negedge clk) begin
        if (cpu_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ready", 32'(cpu_ready), 32'd0);
            end else begin
                chk("sb_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
            end
        end else begin
            chk("rdata_idle_zero", 32'(cpu_rdata), 32'd0);
        end
    end

    initial begin
        logic [15:0] b2b_addr [6];
        logic [7:0]  b2b_exp  [6];
        logic        b2b_rom  [6];

        b2b_addr = '{16'h7E00, 16'h1000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7DFF};
        b2b_exp  = '{8'h10,    8'h4A,    8'h0F,    8'hDA,    8'h5A,    8'hD8};
        b2b_rom  = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0};

        // Reset with a read request held: no strobes, clean state.
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h7E00, 8'h00);
        next();
        next();
        @(negedge clk);
        chk("rst_boot_active", 32'(boot_active), 32'd1);
        chk("rst_wp_fault",    32'(wp_fault),    32'd0);
        chk("rst_ready",       32'(cpu_ready),   32'd0);
        chk("rst_rdata",       32'(cpu_rdata),   32'd0);
        chk("rst_rom_en",      32'(rom_enable),  32'd0);
        chk("rst_ram_en",      32'(ram_enable),  32'd0);
        next();
        reset = 1'b0;
        idle();
        next();

        // ROM read inside the window.
        drive(1'b1, 1'b0, 16'h7E00, 8'h00);
        exp_q.push_back(8'h10);
        @(negedge clk);
        chk("rd_rom_en",   32'(rom_enable), 32'd1);
        chk("rd_rom_addr", 32'(rom_addr),   32'h7E00);
        chk("rd_rom_ram_en", 32'(ram_enable), 32'd0);
        next();
        idle();
        @(negedge clk);
        chk("idle_rom_en",   32'(rom_enable), 32'd0);
        chk("idle_rom_hold", 32'(rom_addr),   32'h7E00);
        next();

        // Wrong key is ignored.
        drive(1'b0, 1'b1, 16'hFFF0, 8'h3C);
        exp_q.push_back(8'h00);
        @(negedge clk);
        chk("ctrl_wr_ram_en", 32'(ram_enable), 32'd0);
        next();
        drive(1'b1, 1'b0, 16'hFFF0, 8'h00);
        exp_q.push_back(8'h01);
        @(negedge clk);
        chk("badkey_boot_active", 32'(boot_active), 32'd1);
        chk("ctrl_rd_ram_en",     32'(ram_enable),  32'd0);
        chk("ctrl_rd_rom_en",     32'(rom_enable),  32'd0);
        next();

        // Write into the mapped window.
        drive(1'b0, 1'b1, 16'h7E10, 8'h55);
        exp_q.push_back(8'h00);
        @(negedge clk);
`ifdef REFLET_BOOT_WP_EN
        chk("wp_ram_en", 32'(ram_enable), 32'd0);
`else
        chk("shadow_ram_en",    32'(ram_enable),   32'd1);
        chk("shadow_ram_we",    32'(ram_write_en), 32'd1);
        chk("shadow_ram_wdata", 32'(ram_wdata),    32'h55);
        chk("shadow_ram_addr",  32'(ram_addr),     32'h7E10);
`endif
        next();
        idle();
        @(negedge clk);
`ifdef REFLET_BOOT_WP_EN
        chk("wp_fault_set", 32'(wp_fault), 32'd1);
`else
        chk("wp_fault_tied", 32'(wp_fault), 32'd0);
`endif
        next();

        // Back-to-back reads including both window edges and 0xFFFF.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, b2b_addr[i], 8'h00);
            exp_q.push_back(b2b_exp[i]);
            @(negedge clk);
            chk("b2b_rom_en", 32'(rom_enable), 32'(b2b_rom[i]));
            chk("b2b_ram_en", 32'(ram_enable), 32'(!b2b_rom[i]));
            next();
        end

        // Read and write together: write only.
        drive(1'b1, 1'b1, 16'h2000, 8'h77);
        exp_q.push_back(8'h00);
        @(negedge clk);
        chk("rw_ram_we",    32'(ram_write_en), 32'd1);
        chk("rw_ram_wdata", 32'(ram_wdata),    32'h77);
        next();

        // Unmap, then the window falls through to RAM.
        drive(1'b0, 1'b1, 16'hFFF0, 8'hA5);
        exp_q.push_back(8'h00);
        next();
        drive(1'b1, 1'b0, 16'h7E01, 8'h00);
        exp_q.push_back(8'h25);
        @(negedge clk);
        chk("unmap_boot_active", 32'(boot_active), 32'd0);
        chk("unmap_ram_en",      32'(ram_enable),  32'd1);
        chk("unmap_ram_addr",    32'(ram_addr),    32'h7E01);
        chk("unmap_rom_en",      32'(rom_enable),  32'd0);
        next();
        drive(1'b1, 1'b0, 16'hFFF0, 8'h00);
        exp_q.push_back(8'h00);
        next();
        drive(1'b1, 1'b0, 16'h7E10, 8'h00);
`ifdef REFLET_BOOT_WP_EN
        exp_q.push_back(8'h34);
`else
        exp_q.push_back(8'h55);
`endif
        next();
        drive(1'b1, 1'b0, 16'h2000, 8'h00);
        exp_q.push_back(8'h77);
        next();
        idle();
        next();
        next();

        // Read in flight, reset next cycle: response cancelled, ROM remapped.
        drive(1'b1, 1'b0, 16'h7E00, 8'h00);
        next();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("cancel_ready", 32'(cpu_ready), 32'd0);
        chk("cancel_rdata", 32'(cpu_rdata), 32'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready",       32'(cpu_ready),   32'd0);
        chk("post_rst_boot_active", 32'(boot_active), 32'd1);
        chk("post_rst_wp_fault",    32'(wp_fault),    32'd0);
        next();
        drive(1'b1, 1'b0, 16'h7E00, 8'h00);
        exp_q.push_back(8'h10);
        @(negedge clk);
        chk("remap_rom_en", 32'(rom_enable), 32'd1);
        next();
        idle();
        next();
        next();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
